qsys_led_button_pio: RTL

Avalon-MM slave input PIO, the reader counterpart of the LED output register. It samples external push-buttons or switches, synchronises and debounces them, and latches edges into a capture register. Raises a level interrupt for edges that are not masked. Sits beside the LED PIO on the same Qsys interconnect; Nios II software reads button state and services the IRQ.

---
 rtl/qsys_led_pio_pkg.sv | 17 +
 rtl/qsys_led_button_pio_if.sv | 19 +
 rtl/qsys_led_debounce.sv | 51 +++++
 rtl/qsys_led_button_pio.sv | 83 ++++++++
 4 files changed

// File: rtl/qsys_led_pio_pkg.sv
// Shared register map and edge-select encodings for the Qsys LED/button PIO blocks.
package qsys_led_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int unsigned EDGE_RISING  = 0;
  localparam int unsigned EDGE_FALLING = 1;
  localparam int unsigned EDGE_ANY     = 2;

  // Counter width for a debounce window; never narrower than one bit.
  function automatic int unsigned deb_cnt_width(input int unsigned cycles);
    return ($clog2(cycles) > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/qsys_led_button_pio_if.sv
// Avalon-MM slave bus plus interrupt line of the button PIO.
interface qsys_led_button_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/qsys_led_debounce.sv
// Single-bit two-flop synchroniser followed by a stability-counting debouncer.
module qsys_led_debounce
  import qsys_led_pio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter logic        RESET_LEVEL     = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din_i,
  output logic deb_o
);

  localparam int unsigned CntW = deb_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            deb_q, deb_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= RESET_LEVEL;
      sync2_q <= RESET_LEVEL;
      deb_q   <= RESET_LEVEL;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any return to agreement restarts the window, so glitches never accumulate.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    if (sync2_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      deb_d = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/qsys_led_button_pio.sv
// Avalon-MM input PIO: debounced button state, edge capture (W1C) and masked level IRQ.
module qsys_led_button_pio
  import qsys_led_pio_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned EDGE_TYPE       = 1,
  parameter logic        RESET_LEVEL     = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     in_port,
  qsys_led_button_pio_if.slave bus
);

  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] deb_prev_q;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] rise, fall, ev, clr;
  logic             wr;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    qsys_led_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_LEVEL    (RESET_LEVEL)
    ) u_debounce (
      .clk    (clk),
      .reset_n(reset_n),
      .din_i  (in_port[i]),
      .deb_o  (deb[i])
    );
  end

  assign wr   = bus.chipselect && !bus.write_n;
  assign rise = deb & ~deb_prev_q;
  assign fall = ~deb & deb_prev_q;

  always_comb begin
    ev = rise | fall;
    case (EDGE_TYPE)
      EDGE_RISING:  ev = rise;
      EDGE_FALLING: ev = fall;
      default:      ev = rise | fall;
    endcase
  end

  // A new edge in the same cycle as its W1C clear wins.
  always_comb begin
    clr       = '0;
    irqmask_d = irqmask_q;
    if (wr && bus.address == ADDR_EDGECAP) clr = bus.writedata[WIDTH-1:0];
    if (wr && bus.address == ADDR_IRQMASK) irqmask_d = bus.writedata[WIDTH-1:0];
    edgecap_d = ev | (edgecap_q & ~clr);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      deb_prev_q <= {WIDTH{RESET_LEVEL}};
      irqmask_q  <= '0;
      edgecap_q  <= '0;
    end else begin
      deb_prev_q <= deb;
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
    end
  end

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_DATA:    bus.readdata = 32'(deb);
      ADDR_IRQMASK: bus.readdata = 32'(irqmask_q);
      ADDR_EDGECAP: bus.readdata = 32'(edgecap_q);
      default:      bus.readdata = '0;
    endcase
  end

  assign bus.irq      = |(edgecap_q & irqmask_q);
  assign unused_wdata = ^bus.writedata;

endmodule
